// File: rtl/bayer_pattern_gen_pkg.sv
// Shared types and constants for the Bayer test-pattern generator.
// Optional feature macro: BAYER_PATTERN_GEN_LFSR_EN (pattern 3 = LFSR noise).
package bayer_pattern_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_LINE   = 3'd2,
        ST_GAP    = 3'd3,
        ST_VBLANK = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAT_CHAN  = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VRAMP = 2'd2,
        PAT_LFSR  = 2'd3
    } pattern_e;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 as right-shift taps (bits 0,2,3,5).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    // One Fibonacci step: feedback enters at the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/bayer_pattern_gen_lfsr.sv
// 16-bit Fibonacci LFSR with frame reload; built only with BAYER_PATTERN_GEN_LFSR_EN.
module bayer_lfsr
    import bayer_pattern_gen_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              reload,
    output logic [LFSR_W-1:0] state
);

    // Reload wins over advance so every frame restarts from the seed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= LFSR_SEED;
        end else if (reload) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/bayer_pattern_gen.sv
// Synthetic fv/lv/data raster source with Bayer-aware test patterns.
// Optional feature macro: BAYER_PATTERN_GEN_LFSR_EN (pattern 3 = LFSR noise,
// otherwise pattern 3 emits zeros and no LFSR is built).
module bayer_pattern_gen
    import bayer_pattern_gen_pkg::*;
#(
    parameter int unsigned PIXEL_BITS = 10,
    parameter int unsigned MAX_COLS   = 1920,
    parameter int unsigned MAX_ROWS   = 1080,
    parameter int unsigned MAX_BLANK  = 1023
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [1:0]                      pattern,
    input  logic [$clog2(MAX_COLS):0]       width,
    input  logic [$clog2(MAX_ROWS):0]       height,
    input  logic [$clog2(MAX_BLANK+1)-1:0]  h_blank,
    input  logic [$clog2(MAX_BLANK+1)-1:0]  v_blank,
    input  logic [PIXEL_BITS-1:0]           ch0_val,
    input  logic [PIXEL_BITS-1:0]           ch1_val,
    input  logic [PIXEL_BITS-1:0]           ch2_val,
    input  logic [PIXEL_BITS-1:0]           ch3_val,
    output logic                            o_fv,
    output logic                            o_lv,
    output logic [PIXEL_BITS-1:0]           o_data,
    output logic                            o_sof,
    output logic                            busy,
    output logic [31:0]                     frame_count
);

    localparam int unsigned W_W   = $clog2(MAX_COLS) + 1;
    localparam int unsigned H_W   = $clog2(MAX_ROWS) + 1;
    localparam int unsigned B_W   = $clog2(MAX_BLANK + 1);
    localparam int unsigned CNT_W = (W_W > B_W) ? W_W : B_W;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [H_W-1:0]        row_q, row_d;
    logic                  launch_c, start_c, frame_done_c;
    logic [PIXEL_BITS-1:0] pix_c;

    pattern_e              cfg_pat;
    logic [W_W-1:0]        cfg_width;
    logic [H_W-1:0]        cfg_height;
    logic [B_W-1:0]        cfg_hb, cfg_vb;
    logic [PIXEL_BITS-1:0] cfg_ch0, cfg_ch1, cfg_ch2, cfg_ch3;

    logic [CNT_W-1:0]      hb_last_c, vb_last_c, w_last_c;
    logic [H_W-1:0]        h_last_c;

    assign launch_c  = enable && (width != '0) && (height != '0);
    assign hb_last_c = CNT_W'(cfg_hb - B_W'(1));
    assign vb_last_c = CNT_W'(cfg_vb - B_W'(1));
    assign w_last_c  = CNT_W'(cfg_width - W_W'(1));
    assign h_last_c  = cfg_height - H_W'(1);

    // State, in-state cycle counter and row index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // Next-state: each phase lasts a fixed count, frames only end after VBLANK.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        start_c      = 1'b0;
        frame_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_c) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                    row_d   = '0;
                    start_c = 1'b1;
                end
            end
            ST_LEAD: begin
                if (cnt_q == hb_last_c) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LINE: begin
                if (cnt_q == w_last_c) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == hb_last_c) begin
                    cnt_d = '0;
                    if (row_q == h_last_c) begin
                        state_d      = ST_VBLANK;
                        frame_done_c = 1'b1;
                    end else begin
                        state_d = ST_LINE;
                        row_d   = row_q + H_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VBLANK: begin
                if (cnt_q == vb_last_c) begin
                    cnt_d = '0;
                    if (launch_c) begin
                        state_d = ST_LEAD;
                        row_d   = '0;
                        start_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame configuration, captured once per frame start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_pat    <= PAT_CHAN;
            cfg_width  <= '0;
            cfg_height <= '0;
            cfg_hb     <= B_W'(1);
            cfg_vb     <= B_W'(1);
            cfg_ch0    <= '0;
            cfg_ch1    <= '0;
            cfg_ch2    <= '0;
            cfg_ch3    <= '0;
        end else if (start_c) begin
            cfg_pat    <= pattern_e'(pattern);
            cfg_width  <= width;
            cfg_height <= height;
            cfg_hb     <= (h_blank == '0) ? B_W'(1) : h_blank;
            cfg_vb     <= (v_blank == '0) ? B_W'(1) : v_blank;
            cfg_ch0    <= ch0_val;
            cfg_ch1    <= ch1_val;
            cfg_ch2    <= ch2_val;
            cfg_ch3    <= ch3_val;
        end
    end

`ifdef BAYER_PATTERN_GEN_LFSR_EN
    logic [LFSR_W-1:0] lfsr_q;

    bayer_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_d == ST_LINE),
        .reload  (start_c),
        .state   (lfsr_q)
    );
`endif

    // Pixel for the upcoming cycle; column index equals the LINE cycle count.
    always_comb begin
        pix_c = '0;
        if (state_d == ST_LINE) begin
            case (cfg_pat)
                PAT_CHAN:  pix_c = row_d[0] ? (cnt_d[0] ? cfg_ch2 : cfg_ch3)
                                            : (cnt_d[0] ? cfg_ch0 : cfg_ch1);
                PAT_HRAMP: pix_c = PIXEL_BITS'(cnt_d);
                PAT_VRAMP: pix_c = PIXEL_BITS'(row_d);
`ifdef BAYER_PATTERN_GEN_LFSR_EN
                PAT_LFSR:  pix_c = PIXEL_BITS'(lfsr_q);
`else
                PAT_LFSR:  pix_c = '0;
`endif
                default:   pix_c = '0;
            endcase
        end
    end

    // Registered raster outputs, aligned with the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_fv        <= 1'b0;
            o_lv        <= 1'b0;
            o_data      <= '0;
            o_sof       <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            o_fv   <= state_d inside {ST_LEAD, ST_LINE, ST_GAP};
            o_lv   <= (state_d == ST_LINE);
            o_data <= pix_c;
            o_sof  <= start_c;
            busy   <= (state_d != ST_IDLE);
            if (frame_done_c) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bayer_pattern_gen.sv
// Randomized self-checking bench for bayer_pattern_gen against a frame-trace model.
module tb_bayer_pattern_gen;

    localparam int unsigned PB = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    pattern = '0;
    logic [11:0]   width = '0;
    logic [11:0]   height = '0;
    logic [9:0]    h_blank = '0;
    logic [9:0]    v_blank = '0;
    logic [PB-1:0] ch0_val = '0, ch1_val = '0, ch2_val = '0, ch3_val = '0;
    logic          o_fv, o_lv, o_sof, busy;
    logic [PB-1:0] o_data;
    logic [31:0]   frame_count;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned exp_fc = 0;
    logic [63:0] exp_q[$];

    bayer_pattern_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern     (pattern),
        .width       (width),
        .height      (height),
        .h_blank     (h_blank),
        .v_blank     (v_blank),
        .ch0_val     (ch0_val),
        .ch1_val     (ch1_val),
        .ch2_val     (ch2_val),
        .ch3_val     (ch3_val),
        .o_fv        (o_fv),
        .o_lv        (o_lv),
        .o_data      (o_data),
        .o_sof       (o_sof),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle snapshot: {fv, lv, sof, busy, data, frame_count}.
    function automatic logic [63:0] pack(input logic fv, input logic lv, input logic sof,
                                         input logic bsy, input logic [PB-1:0] d,
                                         input logic [31:0] fc);
        return {12'd0, fv, lv, sof, bsy, 16'(d), fc};
    endfunction

    function automatic logic [63:0] observe();
        return pack(o_fv, o_lv, o_sof, busy, o_data, frame_count);
    endfunction

    function automatic logic [PB-1:0] ref_pix(input int pat, input int r, input int c,
                                              input logic [PB-1:0] lf_pix);
        case (pat)
            0: begin
                if (r % 2 == 0) return (c % 2 == 1) ? ch0_val : ch1_val;
                else            return (c % 2 == 1) ? ch2_val : ch3_val;
            end
            1: return PB'(c % (1 << PB));
            2: return PB'(r % (1 << PB));
            default: return lf_pix;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        // Taps 16,14,13,11 counted from the output end.
        return {s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11], s[15:1]};
    endfunction

    task automatic randomize_cfg_inputs();
        pattern = 2'($urandom);
        width   = 12'($urandom_range(1, 4095));
        height  = 12'($urandom_range(1, 4095));
        h_blank = 10'($urandom);
        v_blank = 10'($urandom);
        ch0_val = PB'($urandom);
        ch1_val = PB'($urandom);
        ch2_val = PB'($urandom);
        ch3_val = PB'($urandom);
    endtask

    // Runs nf back-to-back frames; enable drops drop_off cycles into the last frame.
    task automatic run_frames(input int w, input int h, input int hbi, input int vbi,
                              input int pat, input int nf, input int drop_off,
                              output int fv_cycles);
        int hb, vb, fv_len, drop_idx;
        logic [15:0] lf;
        logic [PB-1:0] lf_pix;
        logic [63:0] got;
        hb = (hbi == 0) ? 1 : hbi;
        vb = (vbi == 0) ? 1 : vbi;
        fv_len = (h + 1) * hb + h * w;
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            lf = 16'hACE1;
            for (int k = 0; k < hb; k++) exp_q.push_back(pack(1, 0, k == 0, 1, '0, exp_fc));
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
`ifdef BAYER_PATTERN_GEN_LFSR_EN
                    lf_pix = lf[PB-1:0];
`else
                    lf_pix = '0;
`endif
                    exp_q.push_back(pack(1, 1, 0, 1, ref_pix(pat, r, c, lf_pix), exp_fc));
                    lf = lfsr_step(lf);
                end
                for (int k = 0; k < hb; k++) exp_q.push_back(pack(1, 0, 0, 1, '0, exp_fc));
            end
            exp_fc++;
            for (int k = 0; k < vb; k++) exp_q.push_back(pack(0, 0, 0, 1, '0, exp_fc));
        end
        exp_q.push_back(pack(0, 0, 0, 0, '0, exp_fc));
        exp_q.push_back(pack(0, 0, 0, 0, '0, exp_fc));
        drop_idx = (nf - 1) * (fv_len + vb) + drop_off;

        @(negedge clk);
        width   = 12'(w);
        height  = 12'(h);
        h_blank = 10'(hbi);
        v_blank = 10'(vbi);
        pattern = 2'(pat);
        enable  = 1'b1;
        fv_cycles = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got = observe();
            if (o_fv) fv_cycles++;
            check_eq($sformatf("w%0d_h%0d_p%0d_cyc%0d", w, h, pat, i), got, exp_q[i]);
            if (i == drop_idx) begin
                enable = 1'b0;
                randomize_cfg_inputs();
            end
        end
    endtask

    initial begin
        int fvc;
        int w, h, hbi, vbi, pat, nf;
        bit seen;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", observe(), pack(0, 0, 0, 0, '0, 0));
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", observe(), pack(0, 0, 0, 0, '0, 0));

        // Reference frame: GRBG constants, 14-cycle fv, 17-cycle period.
        ch0_val = PB'(1); ch1_val = PB'(2); ch2_val = PB'(3); ch3_val = PB'(4);
        run_frames(4, 2, 2, 3, 0, 2, 5, fvc);
        check_eq("fv_len_plan", 64'(fvc), 64'd28);
        check_eq("frame_count_plan", 64'(frame_count), 64'd2);

        // Column ramp wrapping past 1023, then row ramp.
        run_frames(1100, 2, 1, 1, 1, 1, 0, fvc);
        run_frames(7, 4, 3, 2, 2, 1, 3, fvc);

        // Zero blanking behaves as one cycle.
        run_frames(5, 3, 0, 0, int'($urandom_range(0, 3)), 2, 1, fvc);
        check_eq("fv_len_zero_blank", 64'(fvc), 64'(2 * ((3 + 1) * 1 + 3 * 5)));

        // Zero-size frames never start.
        @(negedge clk);
        width = 12'd5; height = 12'd0; enable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("height_zero_idle", observe(), pack(0, 0, 0, 0, '0, exp_fc));
        end
        width = 12'd0; height = 12'd3;
        repeat (4) begin
            @(negedge clk);
            check_eq("width_zero_idle", observe(), pack(0, 0, 0, 0, '0, exp_fc));
        end
        enable = 1'b0;
        @(negedge clk);

        // Enable dropped mid line 1 of 3: frame still completes.
        ch0_val = PB'(9); ch1_val = PB'(8); ch2_val = PB'(7); ch3_val = PB'(6);
        run_frames(6, 3, 2, 2, 0, 1, 2 + 6 + 2 + 3, fvc);

        // Random configurations, including repeated frames.
        for (int t = 0; t < 8; t++) begin
            w   = int'($urandom_range(1, 20));
            h   = int'($urandom_range(1, 5));
            hbi = int'($urandom_range(0, 4));
            vbi = int'($urandom_range(0, 4));
            pat = int'($urandom_range(0, 3));
            nf  = int'($urandom_range(1, 3));
            ch0_val = PB'($urandom); ch1_val = PB'($urandom);
            ch2_val = PB'($urandom); ch3_val = PB'($urandom);
            run_frames(w, h, hbi, vbi, pat, nf,
                       int'($urandom_range(0, ((h + 1) * ((hbi == 0) ? 1 : hbi) + h * w) - 1)),
                       fvc);
        end

        // Reset pulse in the middle of a line.
        @(negedge clk);
        width = 12'd8; height = 12'd2; h_blank = 10'd1; v_blank = 10'd1;
        pattern = 2'd1; enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (o_lv) seen = 1'b1;
        end
        check_eq("lv_seen_before_reset", 64'(seen), 64'd1);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        check_eq("reset_mid_line", observe(), pack(0, 0, 0, 0, '0, 0));
        reset_n = 1'b1;
        exp_fc  = 0;
        @(negedge clk);
        check_eq("after_reset_release", observe(), pack(0, 0, 0, 0, '0, 0));
        run_frames(3, 1, 1, 1, 1, 1, 0, fvc);
        check_eq("fv_len_after_reset", 64'(fvc), 64'(2 * 1 + 1 * 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bayer_pattern_gen.md
# bayer_pattern_gen

Synthetic image-stream source for the ALS path. It drives the same fv/lv/data raster protocol that the camera front end delivers, and the channel-accumulation logic consumes it. It produces frames of programmable size and blanking, with Bayer-plane-aware test patterns. It sits in front of the statistics blocks as a selectable replacement for sensor input, for bring-up and self-test.

## Interface
- PIXEL_BITS, 10, bits per pixel
- MAX_COLS, 1920, max active columns
- MAX_ROWS, 1080, max active rows
- MAX_BLANK, 1023, max blanking cycles (h or v)

- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run frames continuously while high
- pattern  in  2  0 = per-channel constant, 1 = column ramp, 2 = row ramp, 3 = pseudo-random
- width  in  $clog2(MAX_COLS)+1  active pixels per line
- height  in  $clog2(MAX_ROWS)+1  active lines per frame
- h_blank  in  $clog2(MAX_BLANK+1)  lv-low cycles around/between lines
- v_blank  in  $clog2(MAX_BLANK+1)  fv-low cycles between frames
- ch0_val..ch3_val  in  PIXEL_BITS each  constants for pattern 0
- o_fv  out  1  frame valid
- o_lv  out  1  line valid
- o_data  out  PIXEL_BITS  pixel, qualified by o_lv
- o_sof  out  1  one-cycle pulse on the first o_fv-high cycle
- busy  out  1  high from frame start to end of trailing v_blank
- frame_count  out  32  completed frames, wraps

## Operation
- FSM states:
  - IDLE: fv=0, lv=0.
  - LEAD: fv=1, lv=0 for hb cycles.
  - LINE: fv=1, lv=1 for width cycles.
  - GAP: fv=1, lv=0 for hb cycles after every line.
  - VBLANK: fv=0 for vb cycles.
- hb = max(h_blank,1); vb = max(v_blank,1). This guarantees lv and fv edges are always seen.
- Config sampling: width, height, h_blank, v_blank, pattern and ch*_val are registered on the IDLE/VBLANK→LEAD transition and held for the whole frame.
- IDLE→LEAD when enable=1 and width≠0 and height≠0; otherwise stay in IDLE.
- LEAD→LINE → GAP. GAP→LINE if lines remain; after the last line, GAP→VBLANK.
- VBLANK end: go to LEAD if enable and sizes are valid, else IDLE.
- enable dropped mid-frame: the current frame, including its VBLANK, completes. No truncated frames are ever emitted.
- Row index r and column index c are 0-based within the frame and line.
- Pattern 0 (GRBG mapping):
  - r even, c odd → ch0_val
  - r even, c even → ch1_val
  - r odd, c odd → ch2_val
  - r odd, c even → ch3_val
- Pattern 1: o_data = c[PIXEL_BITS-1:0] (wraps).
- Pattern 2: o_data = r[PIXEL_BITS-1:0].
- o_data = 0 whenever o_lv=0.
- frame_count increments in the cycle o_fv falls (LAST GAP→VBLANK).
- Reset: all outputs, counters and FSM go to 0/IDLE on the next clk edge, including mid-line. Outputs are low on the first cycle after reset release.

## Timing
- All outputs are registered.
- enable sampled high in IDLE at cycle N → o_fv=1 and o_sof=1 at N+1.
- First o_lv high at N+1+hb.
- fv-high duration = (height+1)·hb + height·width cycles. Frame period = that + vb.
- o_data is valid in the same cycle as its o_lv.
- busy drops in the cycle the FSM enters IDLE.

## Configuration
- BAYER_PATTERN_GEN_LFSR_EN defined: pattern 3 is a 16-bit Fibonacci LFSR.
  - Taps 16,14,13,11; seed 16'hACE1 on reset and at every frame start.
  - Advances only on lv-high cycles; o_data = LFSR[PIXEL_BITS-1:0].
- Undefined: pattern 3 outputs constant 0 and no LFSR logic is synthesized.

## Structure
- Package bayer_pattern_gen_pkg holds:
  - the FSM state enum
  - the pattern enum (PAT_CHAN, PAT_HRAMP, PAT_VRAMP, PAT_LFSR)
  - LFSR seed/taps constants
- Sub-module bayer_lfsr (enable, reload, state out), instantiated only under the macro.

## Test plan
- width=4, height=2, h_blank=2, v_blank=3, pattern 0, ch0..3=1,2,3,4 → lines 2,1,2,1 then 4,3,4,3. fv high 14 cycles; period 17; frame_count 1 after first fv fall.
- pattern 1, width=1100, PIXEL_BITS=10 → data 0..1023 then 0..75 on each line; row ramp (pattern 2) constant per line.
- h_blank=0, v_blank=0 → timing identical to 1/1.
- height=0 with enable=1 → o_fv stays 0 and busy=0.
- enable dropped mid-line 1 of 3 → frame completes all 3 lines + VBLANK, then IDLE. frame_count +1.
- reset_n low mid-LINE for 1 cycle → next cycle o_fv=o_lv=o_data=0 and frame_count=0. Restart obeys the N+1 rule.
- LFSR_EN, pattern 3 → first pixels equal successive LFSR states from 16'hACE1, identical every frame.
